// File: rtl/ula_pkg.sv
// Shared types and constants for the nibble-serial 74181-style ALU.
package ula_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int unsigned NIB_W = 4;

    // Function selects (meaning depends on mode)
    localparam logic [3:0] ULA_NOT_A = 4'b0000;
    localparam logic [3:0] ULA_XOR   = 4'b0110;
    localparam logic [3:0] ULA_ADD   = 4'b1001;
    localparam logic [3:0] ULA_AND   = 4'b1011;

    localparam logic ULA_LOGIC = 1'b1;
    localparam logic ULA_ARITH = 1'b0;

endpackage

// File: rtl/ula_serial_8_bits_if.sv
// Request/response bus of the nibble-serial ALU; master drives requests, slave is the ALU.
interface ula_serial_8_bits_if #(
    parameter int unsigned SLICES = 2,
    parameter int unsigned CNT_W  = 16
);
    localparam int unsigned W = 4 * SLICES;

    logic             req_valid;
    logic             req_ready;
    logic [W-1:0]     a;
    logic [W-1:0]     b;
    logic [3:0]       s;
    logic             m;
    logic             c_in;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [W-1:0]     f;
    logic             a_eq_b;
    logic             c_out;
    logic             busy;
    logic [CNT_W-1:0] op_count;

    modport master (
        output req_valid, a, b, s, m, c_in, rsp_ready,
        input  req_ready, rsp_valid, f, a_eq_b, c_out, busy, op_count
    );

    modport slave (
        input  req_valid, a, b, s, m, c_in, rsp_ready,
        output req_ready, rsp_valid, f, a_eq_b, c_out, busy, op_count
    );

endinterface

// File: rtl/ula_4_bits_slice.sv
// Combinational 4-bit 74181 slice, active-high data; arithmetic is X + Y + c_in.
module ula_4_bits_slice
    import ula_pkg::*;
(
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic [3:0] s,
    input  logic       m,
    input  logic       c_in,
    output logic [3:0] f,
    output logic       c_out
);

    logic [3:0] x;
    logic [3:0] y;
    logic [3:0] lf;
    logic [4:0] sum;

    // Arithmetic terms are bitwise in a/b so each nibble can be evaluated independently
    always_comb begin
        x  = a;
        y  = 4'h0;
        lf = 4'h0;
        case (s)
            ULA_NOT_A: begin x = a;        y = 4'h0;    lf = ~a;        end
            4'b0001:   begin x = a | b;    y = 4'h0;    lf = ~(a | b);  end
            4'b0010:   begin x = a | ~b;   y = 4'h0;    lf = ~a & b;    end
            4'b0011:   begin x = 4'h0;     y = 4'hF;    lf = 4'h0;      end
            4'b0100:   begin x = a;        y = a & ~b;  lf = ~(a & b);  end
            4'b0101:   begin x = a | b;    y = a & ~b;  lf = ~b;        end
            ULA_XOR:   begin x = a;        y = ~b;      lf = a ^ b;     end
            4'b0111:   begin x = a & ~b;   y = 4'hF;    lf = a & ~b;    end
            4'b1000:   begin x = a;        y = a & b;   lf = ~a | b;    end
            ULA_ADD:   begin x = a;        y = b;       lf = ~(a ^ b);  end
            4'b1010:   begin x = a | ~b;   y = a & b;   lf = b;         end
            ULA_AND:   begin x = a & b;    y = 4'hF;    lf = a & b;     end
            4'b1100:   begin x = a;        y = a;       lf = 4'hF;      end
            4'b1101:   begin x = a | b;    y = a;       lf = a | ~b;    end
            4'b1110:   begin x = a | ~b;   y = a;       lf = a | b;     end
            default:   begin x = a;        y = 4'hF;    lf = a;         end
        endcase
        sum   = 5'(x) + 5'(y) + 5'(c_in);
        f     = (m == ULA_LOGIC) ? lf : sum[3:0];
        c_out = (m == ULA_LOGIC) ? 1'b0 : sum[4];
    end

endmodule

// File: rtl/ula_serial_8_bits.sv
// Nibble-serial 74181 ALU responder: one 4-bit slice per cycle, LSB first, carry registered.
module ula_serial_8_bits
    import ula_pkg::*;
#(
    parameter int unsigned SLICES = 2,
    parameter int unsigned CNT_W  = 16
)
(
    input logic                clk,
    input logic                rst,
    ula_serial_8_bits_if.slave bus
);

    localparam int unsigned IDX_W = (SLICES > 1) ? $clog2(SLICES) : 1;

    state_t state_q;
    state_t state_next;

    logic [SLICES-1:0][3:0] a_q;
    logic [SLICES-1:0][3:0] b_q;
    logic [SLICES-1:0][3:0] f_q;
    logic [3:0]             s_q;
    logic                   m_q;
    logic                   carry_q;
    logic                   eq_q;
    logic [IDX_W-1:0]       idx_q;

    logic                   req_ready_q;
    logic                   rsp_valid_q;
    logic                   busy_q;
    logic                   a_eq_b_q;
    logic                   c_out_q;
    logic [CNT_W-1:0]       op_count_q;

    logic                   accept_c;
    logic                   retire_c;
    logic                   last_c;
    logic [3:0]             slice_f;
    logic                   slice_cout;
    logic                   nib_eq;

    // Single slice shared across all nibbles, steered by idx_q
    ula_4_bits_slice u_slice (
        .a     (a_q[idx_q]),
        .b     (b_q[idx_q]),
        .s     (s_q),
        .m     (m_q),
        .c_in  (carry_q),
        .f     (slice_f),
        .c_out (slice_cout)
    );

    assign nib_eq = (a_q[idx_q] == b_q[idx_q]);

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_next;
    end

    // Next-state and handshake decode
    always_comb begin
        state_next = state_q;
        accept_c   = 1'b0;
        retire_c   = 1'b0;
        last_c     = (idx_q == IDX_W'(SLICES - 1));
        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    accept_c   = 1'b1;
                    state_next = CALC;
                end
            end
            CALC: begin
                if (last_c) state_next = DONE;
            end
            DONE: begin
                if (bus.rsp_ready) begin
                    retire_c   = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Operand capture, slice datapath and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q         <= '0;
            b_q         <= '0;
            f_q         <= '0;
            s_q         <= 4'h0;
            m_q         <= ULA_ARITH;
            carry_q     <= 1'b0;
            eq_q        <= 1'b0;
            idx_q       <= '0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            a_eq_b_q    <= 1'b0;
            c_out_q     <= 1'b0;
            op_count_q  <= '0;
        end else begin
            req_ready_q <= (state_next == IDLE);
            rsp_valid_q <= (state_next == DONE);
            busy_q      <= (state_next != IDLE);

            if (accept_c) begin
                a_q     <= bus.a;
                b_q     <= bus.b;
                s_q     <= bus.s;
                m_q     <= bus.m;
                carry_q <= bus.c_in;
                eq_q    <= 1'b1;
                idx_q   <= '0;
            end

            if (state_q == CALC) begin
                f_q[idx_q] <= slice_f;
                carry_q    <= slice_cout;
                eq_q       <= eq_q & nib_eq;
                idx_q      <= last_c ? '0 : idx_q + IDX_W'(1);
                if (last_c) begin
                    a_eq_b_q <= eq_q & nib_eq;
                    c_out_q  <= slice_cout;
                end
            end

            if (retire_c) op_count_q <= op_count_q + CNT_W'(1);
        end
    end

    assign bus.req_ready = req_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.busy      = busy_q;
    assign bus.f         = f_q;
    assign bus.a_eq_b    = a_eq_b_q;
    assign bus.c_out     = c_out_q;
    assign bus.op_count  = op_count_q;

endmodule

// File: tb/tb_ula_serial_8_bits.sv
// Directed self-checking bench for the nibble-serial ALU with an 8-bit reference sweep.
module tb_ula_serial_8_bits;
    import ula_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   n_checks  = 0;
    int   n_fail    = 0;
    int   exp_count = 0;

    ula_serial_8_bits_if #(.SLICES(2), .CNT_W(16)) bus ();

    ula_serial_8_bits #(.SLICES(2), .CNT_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Full-width reference: F = X + Y + c_in over 9 bits, or bitwise logic
    function automatic logic [8:0] ref_alu(input logic [7:0] a, input logic [7:0] b,
                                           input logic [3:0] s, input logic m, input logic cin);
        logic [7:0] x, y, l;
        x = a; y = 8'h00; l = 8'h00;
        case (s)
            4'h0: begin x = a;       y = 8'h00;  l = ~a;       end
            4'h1: begin x = a | b;   y = 8'h00;  l = ~(a | b); end
            4'h2: begin x = a | ~b;  y = 8'h00;  l = ~a & b;   end
            4'h3: begin x = 8'h00;   y = 8'hFF;  l = 8'h00;    end
            4'h4: begin x = a;       y = a & ~b; l = ~(a & b); end
            4'h5: begin x = a | b;   y = a & ~b; l = ~b;       end
            4'h6: begin x = a;       y = ~b;     l = a ^ b;    end
            4'h7: begin x = a & ~b;  y = 8'hFF;  l = a & ~b;   end
            4'h8: begin x = a;       y = a & b;  l = ~a | b;   end
            4'h9: begin x = a;       y = b;      l = a ~^ b;   end
            4'hA: begin x = a | ~b;  y = a & b;  l = b;        end
            4'hB: begin x = a & b;   y = 8'hFF;  l = a & b;    end
            4'hC: begin x = a;       y = a;      l = 8'hFF;    end
            4'hD: begin x = a | b;   y = a;      l = a | ~b;   end
            4'hE: begin x = a | ~b;  y = a;      l = a | b;    end
            default: begin x = a;    y = 8'hFF;  l = a;        end
        endcase
        if (m) ref_alu = {1'b0, l};
        else   ref_alu = 9'(x) + 9'(y) + 9'(cin);
    endfunction

    // Issue one request, wait for the response, then consume it
    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic [3:0] s,
                          input logic m, input logic c_in,
                          output logic [7:0] f, output logic eq, output logic cout,
                          output int lat);
        int guard;
        guard = 0;
        while (bus.req_ready !== 1'b1 && guard < 20) begin
            step();
            guard++;
        end
        bus.a = a; bus.b = b; bus.s = s; bus.m = m; bus.c_in = c_in;
        bus.req_valid = 1'b1;
        step();
        bus.req_valid = 1'b0;
        lat = 0;
        while (bus.rsp_valid !== 1'b1 && lat < 20) begin
            step();
            lat++;
        end
        n_checks++;
        if (bus.rsp_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL rsp_timeout: rsp_valid=%b required 1", bus.rsp_valid);
        end
        f = bus.f; eq = bus.a_eq_b; cout = bus.c_out;
        bus.rsp_ready = 1'b1;
        step();
        bus.rsp_ready = 1'b0;
        exp_count++;
    endtask

    task automatic test_reset();
        bus.req_valid = 1'b0; bus.rsp_ready = 1'b0;
        bus.a = 8'h00; bus.b = 8'h00; bus.s = 4'h0; bus.m = 1'b0; bus.c_in = 1'b0;
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        exp_count = 0;
        n_checks += 7;
        if (bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid: got %b want 0", bus.rsp_valid); end
        if (bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_req_ready: got %b want 1", bus.req_ready); end
        if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
        if (bus.f !== 8'h00) begin n_fail++; $display("FAIL reset_f: got %h want 00", bus.f); end
        if (bus.a_eq_b !== 1'b0) begin n_fail++; $display("FAIL reset_a_eq_b: got %b want 0", bus.a_eq_b); end
        if (bus.c_out !== 1'b0) begin n_fail++; $display("FAIL reset_c_out: got %b want 0", bus.c_out); end
        if (bus.op_count !== 16'd0) begin n_fail++; $display("FAIL reset_op_count: got %0d want 0", bus.op_count); end
    endtask

    task automatic test_add_carry();
        logic [7:0] f; logic eq, co; int lat;
        run_op(8'h0F, 8'h01, ULA_ADD, ULA_ARITH, 1'b0, f, eq, co, lat);
        n_checks += 3;
        if (f !== 8'h10) begin n_fail++; $display("FAIL add_carry_f: got %h want 10", f); end
        if (co !== 1'b0) begin n_fail++; $display("FAIL add_carry_cout: got %b want 0", co); end
        if (lat !== 2) begin n_fail++; $display("FAIL add_latency: got %0d want 2", lat); end
    endtask

    task automatic test_arith_wrap();
        logic [7:0] f; logic eq, co; int lat;
        run_op(8'hFF, 8'h01, ULA_ADD, ULA_ARITH, 1'b0, f, eq, co, lat);
        n_checks += 2;
        if (f !== 8'h00) begin n_fail++; $display("FAIL add_wrap_f: got %h want 00", f); end
        if (co !== 1'b1) begin n_fail++; $display("FAIL add_wrap_cout: got %b want 1", co); end
        run_op(8'hAA, 8'hAA, 4'b0110, ULA_ARITH, 1'b1, f, eq, co, lat);
        n_checks += 2;
        if (f !== 8'h00) begin n_fail++; $display("FAIL sub_f: got %h want 00", f); end
        if (co !== 1'b1) begin n_fail++; $display("FAIL sub_cout: got %b want 1", co); end
    endtask

    task automatic test_logic();
        logic [7:0] f; logic eq, co; int lat;
        logic [3:0] sel [3] = '{ULA_XOR, ULA_AND, ULA_NOT_A};
        logic [7:0] want[3] = '{8'hFF, 8'h00, 8'h55};
        for (int i = 0; i < 3; i++) begin
            run_op(8'hAA, 8'h55, sel[i], ULA_LOGIC, 1'b1, f, eq, co, lat);
            n_checks += 2;
            if (f !== want[i]) begin n_fail++; $display("FAIL logic_f s=%b: got %h want %h", sel[i], f, want[i]); end
            if (co !== 1'b0) begin n_fail++; $display("FAIL logic_cout s=%b: got %b want 0", sel[i], co); end
        end
    endtask

    task automatic test_eq();
        logic [7:0] f; logic eq, co; int lat;
        run_op(8'hAA, 8'hAA, 4'b0000, ULA_LOGIC, 1'b0, f, eq, co, lat);
        n_checks++;
        if (eq !== 1'b1) begin n_fail++; $display("FAIL eq_same: got %b want 1", eq); end
        run_op(8'hAA, 8'hAB, 4'b0000, ULA_LOGIC, 1'b0, f, eq, co, lat);
        n_checks++;
        if (eq !== 1'b0) begin n_fail++; $display("FAIL eq_lsb_diff: got %b want 0", eq); end
    endtask

    task automatic test_backpressure();
        int guard;
        bus.a = 8'h3C; bus.b = 8'h05; bus.s = ULA_ADD; bus.m = ULA_ARITH; bus.c_in = 1'b0;
        bus.req_valid = 1'b1;
        step();
        bus.req_valid = 1'b0;
        bus.a = 8'hFF; bus.b = 8'hFF; bus.c_in = 1'b1;
        guard = 0;
        while (bus.rsp_valid !== 1'b1 && guard < 20) begin
            step();
            guard++;
        end
        for (int i = 0; i < 5; i++) begin
            n_checks += 5;
            if (bus.rsp_valid !== 1'b1) begin n_fail++; $display("FAIL bp_rsp_valid[%0d]: got %b want 1", i, bus.rsp_valid); end
            if (bus.f !== 8'h41) begin n_fail++; $display("FAIL bp_f[%0d]: got %h want 41", i, bus.f); end
            if (bus.c_out !== 1'b0) begin n_fail++; $display("FAIL bp_cout[%0d]: got %b want 0", i, bus.c_out); end
            if (bus.req_ready !== 1'b0) begin n_fail++; $display("FAIL bp_req_ready[%0d]: got %b want 0", i, bus.req_ready); end
            if (bus.op_count !== 16'(exp_count)) begin n_fail++; $display("FAIL bp_op_count[%0d]: got %0d want %0d", i, bus.op_count, exp_count); end
            step();
        end
        bus.rsp_ready = 1'b1;
        step();
        bus.rsp_ready = 1'b0;
        exp_count++;
        n_checks += 3;
        if (bus.op_count !== 16'(exp_count)) begin n_fail++; $display("FAIL bp_op_count_after: got %0d want %0d", bus.op_count, exp_count); end
        if (bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL bp_rsp_valid_after: got %b want 0", bus.rsp_valid); end
        if (bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL bp_req_ready_after: got %b want 1", bus.req_ready); end
    endtask

    task automatic test_reset_mid_calc();
        bus.a = 8'h12; bus.b = 8'h34; bus.s = ULA_ADD; bus.m = ULA_ARITH; bus.c_in = 1'b0;
        bus.req_valid = 1'b1;
        step();
        bus.req_valid = 1'b0;
        n_checks++;
        if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL mid_busy: got %b want 1", bus.busy); end
        rst = 1'b1;
        step();
        rst = 1'b0;
        exp_count = 0;
        n_checks += 3;
        if (bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL mid_rst_rsp_valid: got %b want 0", bus.rsp_valid); end
        if (bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL mid_rst_req_ready: got %b want 1", bus.req_ready); end
        if (bus.op_count !== 16'd0) begin n_fail++; $display("FAIL mid_rst_op_count: got %0d want 0", bus.op_count); end
        for (int i = 0; i < 4; i++) begin
            step();
            n_checks++;
            if (bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL mid_rst_no_rsp[%0d]: got %b want 0", i, bus.rsp_valid); end
        end
    endtask

    task automatic test_sweep();
        logic [7:0] f; logic eq, co; int lat;
        logic [8:0] want;
        logic [7:0] va[3] = '{8'hC6, 8'h0F, 8'h77};
        logic [7:0] vb[3] = '{8'h3B, 8'hF1, 8'h77};
        logic       vc[3] = '{1'b0, 1'b1, 1'b1};
        for (int mm = 0; mm < 2; mm++) begin
            for (int ss = 0; ss < 16; ss++) begin
                for (int v = 0; v < 3; v++) begin
                    want = ref_alu(va[v], vb[v], 4'(ss), 1'(mm), vc[v]);
                    run_op(va[v], vb[v], 4'(ss), 1'(mm), vc[v], f, eq, co, lat);
                    n_checks++;
                    if (f !== want[7:0] || co !== want[8] || eq !== (va[v] == vb[v])) begin
                        n_fail++;
                        $display("FAIL sweep m=%0d s=%h a=%h b=%h cin=%b: got f=%h c=%b eq=%b want f=%h c=%b eq=%b",
                                 mm, ss, va[v], vb[v], vc[v], f, co, eq, want[7:0], want[8], va[v] == vb[v]);
                    end
                end
            end
        end
    endtask

    task automatic test_op_count();
        n_checks++;
        if (bus.op_count !== 16'(exp_count)) begin n_fail++; $display("FAIL op_count_total: got %0d want %0d", bus.op_count, exp_count); end
    endtask

    initial begin
        test_reset();
        test_add_carry();
        test_arith_wrap();
        test_logic();
        test_eq();
        test_backpressure();
        test_reset_mid_calc();
        test_sweep();
        test_op_count();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
